// File: rtl/sd_wb_rd_align_pkg.sv
// rtl/sd_wb_rd_align_pkg.sv - shared types and byte-lane helpers for the Wishbone read aligner
package sd_wb_rd_align_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    // Lane enable of the final word; a zero remainder means the word is full.
    function automatic logic [3:0] final_be(input logic [1:0] rem);
        logic [3:0] be;
        case (rem)
            2'd0:    be = 4'hf;
            2'd1:    be = 4'h8;
            2'd2:    be = 4'hc;
            default: be = 4'he;
        endcase
        return be;
    endfunction

    // Big-endian lane order: offset k selects bits [31-8k:24-8k] as the first byte.
    function automatic logic [31:0] merge_word(input logic [31:0] hold,
                                               input logic [31:0] din,
                                               input logic [1:0]  k,
                                               input logic [3:0]  be);
        logic [31:0] w;
        case (k)
            2'd0:    w = din;
            2'd1:    w = {hold[23:0], din[31:24]};
            2'd2:    w = {hold[15:0], din[31:16]};
            default: w = {hold[7:0],  din[31:8]};
        endcase
        return w & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/sd_wb_byte_merge.sv
// rtl/sd_wb_byte_merge.sv - combines the held word with the incoming word and masks unused lanes
module sd_wb_byte_merge
    import sd_wb_rd_align_pkg::*;
(
    input  logic [31:0] hold_i,
    input  logic [31:0] in_i,
    input  logic [1:0]  off_i,
    input  logic [3:0]  be_i,
    output logic [31:0] data_o
);

    assign data_o = merge_word(hold_i, in_i, off_i, be_i);

endmodule

// File: rtl/sd_wb_rd_aligner.sv
// rtl/sd_wb_rd_aligner.sv - packs unaligned Wishbone read words into a left-justified TX FIFO stream
// Optional abort input enabled by defining SD_WB_RD_ALIGN_ABORT_EN.
module sd_wb_rd_aligner
    import sd_wb_rd_align_pkg::*;
#(
    parameter int BLKSIZE_W = 12
) (
    input  logic                 wb_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          base_adr_i,
    input  logic [BLKSIZE_W-1:0] blksize,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [3:0]           out_be,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
`ifdef SD_WB_RD_ALIGN_ABORT_EN
    ,
    input  logic                 abort_i
`endif
);

    localparam int CW = BLKSIZE_W + 1;

    state_t        state_q, state_d;
    logic [1:0]    off_q;
    logic [3:0]    fin_be_q;
    logic [CW-1:0] in_cnt_q, out_cnt_q;
    logic [CW-1:0] in_cnt_init, out_cnt_init;
    logic [31:0]   hold_q;
    logic          out_valid_q, out_last_q, done_q;
    logic [3:0]    out_be_q;
    logic [31:0]   out_data_q;
    logic          abort, in_hs, out_hs, out_free, load_word, use_flush;
    logic [3:0]    be_cur;
    logic [31:0]   merge_in, merged;
    logic          unused_adr;

    assign unused_adr = ^base_adr_i[31:2];

`ifdef SD_WB_RD_ALIGN_ABORT_EN
    assign abort = abort_i && (state_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign in_cnt_init  = (CW'(base_adr_i[1:0]) + CW'(blksize) + CW'(3)) >> 2;
    assign out_cnt_init = (CW'(blksize) + CW'(3)) >> 2;

    assign out_free = !out_valid_q || out_ready;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign be_cur   = (out_cnt_q == CW'(1)) ? fin_be_q : 4'hf;
    assign merge_in = use_flush ? 32'h0 : in_data;

    sd_wb_byte_merge u_merge (
        .hold_i (hold_q),
        .in_i   (merge_in),
        .off_i  (off_q),
        .be_i   (be_cur),
        .data_o (merged)
    );

    always_ff @(posedge wb_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && blksize != '0) begin
                    state_d = (base_adr_i[1:0] != 2'd0) ? PRIME : RUN;
                end
            end
            PRIME: begin
                if (in_hs) state_d = RUN;
            end
            RUN: begin
                // in_cnt never exceeds out_cnt here, so the last output also drains the input side
                if (in_hs) begin
                    if (out_cnt_q == CW'(1))     state_d = DRAIN;
                    else if (in_cnt_q == CW'(1)) state_d = FLUSH;
                end else if (in_cnt_q == '0) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (load_word) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_hs && out_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        in_ready  = 1'b0;
        load_word = 1'b0;
        use_flush = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            PRIME: in_ready = 1'b1;
            RUN: begin
                in_ready  = (in_cnt_q != '0) && out_free;
                load_word = in_valid && in_ready;
            end
            FLUSH: begin
                use_flush = 1'b1;
                load_word = out_free;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk or negedge rst) begin
        if (!rst) begin
            off_q     <= 2'd0;
            fin_be_q  <= 4'h0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            hold_q    <= 32'h0;
        end else if (abort) begin
            off_q     <= 2'd0;
            fin_be_q  <= 4'h0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            hold_q    <= 32'h0;
        end else begin
            if (state_q == IDLE && start) begin
                off_q     <= base_adr_i[1:0];
                fin_be_q  <= final_be(blksize[1:0]);
                in_cnt_q  <= in_cnt_init;
                out_cnt_q <= out_cnt_init;
            end
            if (in_hs) begin
                hold_q   <= in_data;
                in_cnt_q <= in_cnt_q - CW'(1);
            end
            if (load_word) begin
                out_cnt_q <= out_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_be_q    <= 4'h0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= !abort &&
                      ((state_q == IDLE && start && blksize == '0) ||
                       (state_q == DRAIN && out_hs && out_last_q));
            if (abort) begin
                out_valid_q <= 1'b0;
                out_data_q  <= 32'h0;
                out_be_q    <= 4'h0;
                out_last_q  <= 1'b0;
            end else if (load_word) begin
                out_valid_q <= 1'b1;
                out_data_q  <= merged;
                out_be_q    <= be_cur;
                out_last_q  <= (out_cnt_q == CW'(1));
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_data_q  <= 32'h0;
                out_be_q    <= 4'h0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_be    = out_be_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sd_wb_rd_aligner.sv
// tb/tb_sd_wb_rd_aligner.sv - directed self-checking bench for sd_wb_rd_aligner
module tb_sd_wb_rd_aligner;

    logic        wb_clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_adr_i;
    logic [11:0] blksize;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef SD_WB_RD_ALIGN_ABORT_EN
    logic        abort_i;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] src[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_be[$];
    logic        exp_last[$];

    sd_wb_rd_aligner #(.BLKSIZE_W(12)) dut (
        .wb_clk     (wb_clk),
        .rst        (rst),
        .start      (start),
        .base_adr_i (base_adr_i),
        .blksize    (blksize),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_be     (out_be),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
`ifdef SD_WB_RD_ALIGN_ABORT_EN
        ,
        .abort_i    (abort_i)
`endif
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input string name, input logic [31:0] base, input logic [11:0] bsz,
                            input int stall_from, input int stall_len, input int exp_taken);
        int          idx;
        int          done_it;
        int          last_out_it;
        int          n_out;
        logic [31:0] snap;
        logic        snap_ok;
        idx = 0; done_it = -1; last_out_it = -1; n_out = 0; snap = 32'h0; snap_ok = 1'b0;
        @(negedge wb_clk);
        start = 1'b1; base_adr_i = base; blksize = bsz; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge wb_clk);
        start = 1'b0;
        for (int it = 0; it < 60 && done_it < 0; it++) begin
            in_valid  = (idx < src.size());
            in_data   = in_valid ? src[idx] : 32'h0;
            out_ready = !(it >= stall_from && it < stall_from + stall_len);
            #4;
            if (done) done_it = it;
            if (!out_ready && out_valid) begin
                chk_eq({name, ":stall_in_ready"}, {31'h0, in_ready}, 32'h0);
                if (snap_ok) chk_eq({name, ":stall_data"}, out_data, snap);
                else begin
                    snap    = out_data;
                    snap_ok = 1'b1;
                end
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                if (n_out < exp_data.size()) begin
                    chk_eq({name, ":data"}, out_data, exp_data[n_out]);
                    chk_eq({name, ":be"}, {28'h0, out_be}, {28'h0, exp_be[n_out]});
                    chk_eq({name, ":last"}, {31'h0, out_last}, {31'h0, exp_last[n_out]});
                end
                n_out++;
                last_out_it = it;
            end
            @(negedge wb_clk);
        end
        in_valid = 1'b0;
        chk_eq({name, ":done_seen"}, {31'h0, done_it >= 0}, 32'h1);
        chk_eq({name, ":done_timing"}, done_it, (last_out_it < 0) ? 0 : last_out_it + 1);
        chk_eq({name, ":n_out"}, n_out, exp_data.size());
        chk_eq({name, ":taken"}, idx, exp_taken);
        #4;
        chk_eq({name, ":done_pulse"}, {31'h0, done}, 32'h0);
        chk_eq({name, ":busy_after"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; base_adr_i = 32'h0; blksize = 12'h0;
        in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
`ifdef SD_WB_RD_ALIGN_ABORT_EN
        abort_i = 1'b0;
`endif
        repeat (3) @(negedge wb_clk);
        chk_eq("rst:out_valid", {31'h0, out_valid}, 32'h0);
        chk_eq("rst:in_ready", {31'h0, in_ready}, 32'h0);
        chk_eq("rst:busy", {31'h0, busy}, 32'h0);
        chk_eq("rst:done", {31'h0, done}, 32'h0);
        chk_eq("rst:out_data", out_data, 32'h0);
        rst = 1'b1;

        src = {32'h11223344, 32'hDEADBEEF};
        exp_data = {32'h22000000}; exp_be = {4'h8}; exp_last = {1'b1};
        run_xfer("b1s1", 32'h0000_1001, 12'd1, 100, 0, 1);

        src = {32'hAABBCCDD, 32'h01020304};
        exp_data = {32'hAABBCCDD, 32'h01020304}; exp_be = {4'hf, 4'hf}; exp_last = {1'b0, 1'b1};
        run_xfer("b0s8", 32'h0000_2000, 12'd8, 100, 0, 2);

        src = {32'h11223344, 32'h55667788};
        exp_data = {32'h22334455}; exp_be = {4'hf}; exp_last = {1'b1};
        run_xfer("b1s4", 32'h0000_0001, 12'd4, 100, 0, 2);

        src = {32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
        exp_data = {32'hA3B0B1B2, 32'hB3C00000}; exp_be = {4'hf, 4'hc}; exp_last = {1'b0, 1'b1};
        run_xfer("b3s6", 32'h0000_0003, 12'd6, 100, 0, 3);

        src = {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        exp_data = {32'h02030405, 32'h06070809, 32'h0A0B0C0D};
        exp_be = {4'hf, 4'hf, 4'hf}; exp_last = {1'b0, 1'b0, 1'b1};
        run_xfer("b2s12_stall", 32'h0000_0002, 12'd12, 3, 3, 4);

        src = {32'h12345678};
        exp_data = {}; exp_be = {}; exp_last = {};
        run_xfer("empty", 32'h0000_0000, 12'd0, 100, 0, 0);

        // reset while RUN holds a word in the output register
        @(negedge wb_clk);
        start = 1'b1; base_adr_i = 32'h0; blksize = 12'd16; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge wb_clk);
        start = 1'b0; in_valid = 1'b1; in_data = 32'hCAFEF00D;
        @(negedge wb_clk);
        in_valid = 1'b0;
        chk_eq("mrst:pre_valid", {31'h0, out_valid}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk_eq("mrst:out_valid", {31'h0, out_valid}, 32'h0);
        chk_eq("mrst:busy", {31'h0, busy}, 32'h0);
        chk_eq("mrst:in_ready", {31'h0, in_ready}, 32'h0);
        chk_eq("mrst:out_data", out_data, 32'h0);
        chk_eq("mrst:out_be", {28'h0, out_be}, 32'h0);
        chk_eq("mrst:out_last", {31'h0, out_last}, 32'h0);
        @(negedge wb_clk);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge wb_clk);
        chk_eq("mrst:no_done", {31'h0, done}, 32'h0);
        chk_eq("mrst:idle", {31'h0, busy}, 32'h0);

`ifdef SD_WB_RD_ALIGN_ABORT_EN
        @(negedge wb_clk);
        start = 1'b1; base_adr_i = 32'h0; blksize = 12'd16; out_ready = 1'b0;
        @(negedge wb_clk);
        start = 1'b0; in_valid = 1'b1; in_data = 32'h0BADF00D;
        @(negedge wb_clk);
        in_valid = 1'b0;
        chk_eq("abort:pre_valid", {31'h0, out_valid}, 32'h1);
        abort_i = 1'b1;
        @(negedge wb_clk);
        abort_i = 1'b0;
        chk_eq("abort:out_valid", {31'h0, out_valid}, 32'h0);
        chk_eq("abort:busy", {31'h0, busy}, 32'h0);
        chk_eq("abort:in_ready", {31'h0, in_ready}, 32'h0);
        chk_eq("abort:no_done0", {31'h0, done}, 32'h0);
        @(negedge wb_clk);
        chk_eq("abort:no_done1", {31'h0, done}, 32'h0);
        out_ready = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
